timer_ctrl: RTL and testbench

- Control stage directly upstream of the counter block; drives its enable, load and cnt_in inputs and consumes its overflow output.
- Turns the counter into a programmable timer: loadable period, clock prescaler, one-shot or periodic mode, and a sticky interrupt with acknowledge.
- Software-style control through start/stop pulses; irq goes to the system interrupt logic.

---
 rtl/timer_ctrl.sv | 118 +++++++++++
 tb/tb_timer_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Programmable timer control in front of an up-counter: prescaler, one-shot/periodic, sticky irq.
// Optional TIMER_CTRL_OVERRUN_EN adds a sticky overrun flag for expiries missed by software.
module timer_ctrl #(
    parameter int unsigned counter_size  = 32,
    parameter int unsigned prescale_size = 8
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode_periodic,
    input  logic [counter_size-1:0]  reload_val,
    input  logic [prescale_size-1:0] prescale,
    input  logic                     irq_ack,
    input  logic                     cnt_overflow,
    output logic                     cnt_enable,
    output logic                     cnt_load,
    output logic [counter_size-1:0]  cnt_load_val,
    output logic                     irq,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                   state_q, state_d;
    logic [counter_size-1:0]  reload_q, reload_d;
    logic [prescale_size-1:0] prescale_q, prescale_d;
    logic [prescale_size-1:0] pre_cnt_q, pre_cnt_d;
    logic                     periodic_q, periodic_d;
    logic                     ovf_prev_q;
    logic                     irq_q, irq_d;
    logic                     in_run, expiry, start_ok, pre_hit;

    always_comb begin
        in_run   = (state_q == StRun);
        pre_hit  = (pre_cnt_q == prescale_q);
        // Edge detect so a counter that holds overflow high still expires only once.
        expiry   = in_run && cnt_overflow && !ovf_prev_q;
        start_ok = start && !stop && ((state_q != StIdle) || (reload_val != '0));

        state_d    = state_q;
        reload_d   = reload_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        pre_cnt_d  = '0;

        if (start_ok) begin
            reload_d   = reload_val;
            prescale_d = prescale;
            periodic_d = mode_periodic;
        end

        if (in_run && !pre_hit) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle:  state_d = StIdle;
            StLoad:  state_d = StRun;
            StRun:   if (expiry) state_d = periodic_q ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase

        if (start_ok) state_d = StLoad;
        if (stop)     state_d = StIdle;

        irq_d = expiry || (irq_q && !irq_ack);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= StIdle;
            reload_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            pre_cnt_q  <= '0;
            ovf_prev_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            pre_cnt_q  <= pre_cnt_d;
            ovf_prev_q <= cnt_overflow;
            irq_q      <= irq_d;
        end
    end

    // Loading the negated period makes the up-counter wrap after exactly reload_q ticks.
    assign cnt_load_val = '0 - reload_q;
    assign cnt_load     = (state_q == StLoad);
    assign cnt_enable   = in_run && pre_hit;
    assign busy         = (state_q != StIdle);
    assign irq          = irq_q;

`ifdef TIMER_CTRL_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = (expiry && irq_q && !irq_ack) || (overrun_q && !irq_ack);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl driving a behavioural up-counter with combinational wrap overflow.
module tb_timer_ctrl;

    logic        clk;
    logic        res_n;
    logic        start;
    logic        stop;
    logic        mode_periodic;
    logic [31:0] reload_val;
    logic [7:0]  prescale;
    logic        irq_ack;
    logic        cnt_overflow;
    logic        cnt_enable;
    logic        cnt_load;
    logic [31:0] cnt_load_val;
    logic        irq;
    logic        busy;
    logic        overrun;

    logic [31:0] cnt_q;

    int n_vec;
    int n_err;
    int cyc;
    int n_en;
    int n_ld;
    int first_en;
    int ld_cyc [4];
    int c0;

`ifdef TIMER_CTRL_OVERRUN_EN
    localparam logic OvrExp = 1'b1;
`else
    localparam logic OvrExp = 1'b0;
`endif

    timer_ctrl #(
        .counter_size  (32),
        .prescale_size (8)
    ) u_dut (
        .clk           (clk),
        .res_n         (res_n),
        .start         (start),
        .stop          (stop),
        .mode_periodic (mode_periodic),
        .reload_val    (reload_val),
        .prescale      (prescale),
        .irq_ack       (irq_ack),
        .cnt_overflow  (cnt_overflow),
        .cnt_enable    (cnt_enable),
        .cnt_load      (cnt_load),
        .cnt_load_val  (cnt_load_val),
        .irq           (irq),
        .busy          (busy),
        .overrun       (overrun)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)          cnt_q <= '0;
        else if (cnt_load)   cnt_q <= cnt_load_val;
        else if (cnt_enable) cnt_q <= cnt_q + 32'd1;
    end

    assign cnt_overflow = cnt_enable && !cnt_load && (cnt_q == 32'hFFFF_FFFF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cnt_enable) begin
            n_en++;
            if (first_en < 0) first_en = cyc;
        end
        if (cnt_load) begin
            if (n_ld < 4) ld_cyc[n_ld] = cyc;
            n_ld++;
        end
    endtask

    task automatic clr();
        n_en     = 0;
        n_ld     = 0;
        first_en = -1;
    endtask

    task automatic start_timer(input logic [31:0] rv, input logic [7:0] ps, input logic per);
        reload_val    = rv;
        prescale      = ps;
        mode_periodic = per;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        clr();
        res_n = 1'b0; start = 1'b0; stop = 1'b0; mode_periodic = 1'b0;
        reload_val = '0; prescale = '0; irq_ack = 1'b0;
        step();
        step();
        check_val("rst_enable", {31'd0, cnt_enable}, 32'd0);
        check_val("rst_load", {31'd0, cnt_load}, 32'd0);
        check_val("rst_load_val", cnt_load_val, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        res_n = 1'b1;
        step();

        // One-shot, reload 4, no prescale
        clr();
        start_timer(32'd4, 8'd0, 1'b0);
        check_val("os_load", {31'd0, cnt_load}, 32'd1);
        check_val("os_load_val", cnt_load_val, 32'hFFFF_FFFC);
        for (int i = 0; i < 50 && !irq; i++) step();
        check_val("os_irq", {31'd0, irq}, 32'd1);
        check_val("os_enables", n_en, 32'd4);
        check_val("os_busy_after", {31'd0, busy}, 32'd0);
        step();
        step();
        check_val("os_no_more_en", n_en, 32'd4);
        ack();
        check_val("os_ack_clears", {31'd0, irq}, 32'd0);

        // Periodic, reload 3, prescale 2
        clr();
        c0 = cyc;
        start_timer(32'd3, 8'd2, 1'b1);
        while (cyc < c0 + 20) step();
        check_val("pre_enables", n_en, 32'd6);
        check_val("pre_loads", n_ld, 32'd2);
        check_val("pre_first_en", first_en - ld_cyc[0], 32'd3);
        check_val("pre_period1", ld_cyc[1] - ld_cyc[0], 32'd10);
        check_val("pre_irq", {31'd0, irq}, 32'd1);
        ack();
        check_val("race_irq_kept", {31'd0, irq}, 32'd1);
        check_val("pre_period2", ld_cyc[2] - ld_cyc[1], 32'd10);
        step();
        step();
        ack();
        check_val("lone_ack_irq", {31'd0, irq}, 32'd0);
        check_val("race_no_overrun", {31'd0, overrun}, 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("pre_stop_busy", {31'd0, busy}, 32'd0);

        // Stop mid-run after 10 enables
        clr();
        start_timer(32'd100, 8'd0, 1'b0);
        for (int i = 0; i < 40 && n_en < 10; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("stop_enables", n_en, 32'd10);
        check_val("stop_en_low", {31'd0, cnt_enable}, 32'd0);
        check_val("stop_irq", {31'd0, irq}, 32'd0);
        check_val("stop_busy", {31'd0, busy}, 32'd0);
        reload_val = 32'd5;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        check_val("ss_busy", {31'd0, busy}, 32'd0);
        check_val("ss_loads", n_ld, 32'd1);

        // Restart during RUN, then async reset mid-run
        clr();
        start_timer(32'd50, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_val("rs_busy", {31'd0, busy}, 32'd1);
        start_timer(32'd7, 8'd0, 1'b0);
        check_val("rs_load", {31'd0, cnt_load}, 32'd1);
        check_val("rs_load_val", cnt_load_val, 32'hFFFF_FFF9);
        step();
        step();
        check_val("rs_run_en", {31'd0, cnt_enable}, 32'd1);
        #1 res_n = 1'b0;
        #1;
        check_val("ar_enable", {31'd0, cnt_enable}, 32'd0);
        check_val("ar_busy", {31'd0, busy}, 32'd0);
        check_val("ar_load_val", cnt_load_val, 32'd0);
        step();
        res_n = 1'b1;
        step();
        start_timer(32'd0, 8'd0, 1'b1);
        check_val("zero_load", {31'd0, cnt_load}, 32'd0);
        step();
        check_val("zero_busy", {31'd0, busy}, 32'd0);

        // Back-to-back expiries without ack; last one coincides with stop
        clr();
        start_timer(32'd1, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check_val("ovr_irq", {31'd0, irq}, 32'd1);
        check_val("ovr_set", {31'd0, overrun}, {31'd0, OvrExp});
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("ovr_stop_busy", {31'd0, busy}, 32'd0);
        check_val("ovr_stop_irq", {31'd0, irq}, 32'd1);
        ack();
        check_val("ovr_ack_irq", {31'd0, irq}, 32'd0);
        check_val("ovr_ack_clr", {31'd0, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
